// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings for the snake game-step engine.
// Directions, pixel colours, engine states and a direction helper.
package snake_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] GREEN = 3'b010;

  typedef enum logic [3:0] {
    INIT_HEAD,
    INIT_FOOD,
    IDLE,
    STEP,
    CHECK,
    ERASE,
    HEAD,
    FOOD_WAIT,
    FOOD_DRAW,
    DEAD
  } state_t;

  // LEFT<->RIGHT and UP<->DOWN differ only in bit 0.
  function automatic dir_t opposite(dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_engine_if.sv
// snake_engine_if: draw command and food request handshakes.
// master = engine (draw_*, food_req out), slave = VGA/food side.
interface snake_engine_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  import snake_pkg::*;

  logic           draw_valid;
  logic           draw_ready;
  logic [X_W-1:0] draw_x;
  logic [Y_W-1:0] draw_y;
  logic [2:0]     draw_colour;
  logic           food_req;
  logic           food_valid;
  logic [X_W-1:0] food_x;
  logic [Y_W-1:0] food_y;

  modport master (
    output draw_valid, draw_x, draw_y, draw_colour, food_req,
    input  draw_ready, food_valid, food_x, food_y
  );

  modport slave (
    input  draw_valid, draw_x, draw_y, draw_colour, food_req,
    output draw_ready, food_valid, food_x, food_y
  );

endinterface

// File: rtl/snake_body_ring.sv
// snake_body_ring: MAX_LEN ring of body cells, head push, tail pop.
// Ports: push/push_x/push_y, pop, rd_off (from tail); head/tail/rd cells out.
module snake_body_ring
  import snake_pkg::*;
#(
  parameter  int MAX_LEN = 128,
  parameter  int X_W     = 8,
  parameter  int Y_W     = 7,
  parameter  int START_X = 0,
  parameter  int START_Y = 0,
  localparam int PW      = $clog2(MAX_LEN)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [X_W-1:0] push_x,
  input  logic [Y_W-1:0] push_y,
  input  logic           pop,
  input  logic [PW-1:0]  rd_off,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [X_W-1:0] tail_x,
  output logic [Y_W-1:0] tail_y,
  output logic [X_W-1:0] rd_x,
  output logic [Y_W-1:0] rd_y
);

  logic [X_W-1:0] mem_x [MAX_LEN];
  logic [Y_W-1:0] mem_y [MAX_LEN];
  logic [PW-1:0]  hp;
  logic [PW-1:0]  tp;
  logic [PW-1:0]  hp_nx;
  logic [PW-1:0]  rd_ptr;

  assign hp_nx  = hp + 1'b1;
  assign rd_ptr = tp + rd_off;

  always_ff @(posedge clk) begin
    if (reset) begin
      hp <= '0;
      tp <= '0;
    end else begin
      if (push) hp <= hp_nx;
      if (pop)  tp <= tp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_x[0] <= X_W'(START_X);
      mem_y[0] <= Y_W'(START_Y);
    end else if (push) begin
      mem_x[hp_nx] <= push_x;
      mem_y[hp_nx] <= push_y;
    end
  end

  assign head_x = mem_x[hp];
  assign head_y = mem_y[hp];
  assign tail_x = mem_x[tp];
  assign tail_y = mem_y[tp];
  assign rd_x   = mem_x[rd_ptr];
  assign rd_y   = mem_y[rd_ptr];

endmodule

// File: rtl/snake_engine.sv
// snake_engine: per-tick snake step -> pixel draw commands over bus.
// Ports: clk, reset, tick, dir_valid/dir_req, bus (draw + food), length,
// game_over. Define SNAKE_WRAP_EN to wrap at the playfield edges.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W  = 160,
  parameter int GRID_H  = 120,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int MAX_LEN = 128,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     dir_valid,
  input  logic [1:0]               dir_req,
  snake_engine_if.master           bus,
  output logic [$clog2(MAX_LEN):0] length,
  output logic                     game_over
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;
  localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [LW-1:0]  LEN_MAX = LW'(MAX_LEN);

  state_t         state;
  dir_t           dir_pend;
  dir_t           dir_com;
  dir_t           cmt_dir;
  logic [X_W-1:0] food_x;
  logic [Y_W-1:0] food_y;
  logic [X_W-1:0] nh_x;
  logic [Y_W-1:0] nh_y;
  logic [X_W-1:0] nx_c;
  logic [Y_W-1:0] ny_c;
  logic           off_edge;
  logic           hit_food;
  logic           grow;
  logic [PW-1:0]  scan_off;
  logic [LW-1:0]  scan_left;
  logic           accept;
  logic           push;
  logic           pop;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  logic [X_W-1:0] tail_x;
  logic [Y_W-1:0] tail_y;
  logic [X_W-1:0] rd_x;
  logic [Y_W-1:0] rd_y;

  snake_body_ring #(
    .MAX_LEN (MAX_LEN),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .START_X (START_X),
    .START_Y (START_Y)
  ) u_ring (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .push_x (nh_x),
    .push_y (nh_y),
    .pop    (pop),
    .rd_off (scan_off),
    .head_x (head_x),
    .head_y (head_y),
    .tail_x (tail_x),
    .tail_y (tail_y),
    .rd_x   (rd_x),
    .rd_y   (rd_y)
  );

  assign accept = bus.draw_valid && bus.draw_ready;
  assign push   = (state == HEAD) && accept;
  // At full length a meal keeps the length: tail leaves as head enters.
  assign pop    = ((state == ERASE) && accept)
               || (push && grow && (length == LEN_MAX));

  // During STEP the pending direction is about to become committed.
  assign cmt_dir = (state == STEP) ? dir_pend : dir_com;

  always_comb begin
    nx_c     = head_x;
    ny_c     = head_y;
    off_edge = 1'b0;
    unique case (1'b1)
      (dir_pend == LEFT): begin
        if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
          nx_c = X_MAX;
`else
          off_edge = 1'b1;
`endif
        end else begin
          nx_c = head_x - 1'b1;
        end
      end
      (dir_pend == RIGHT): begin
        if (head_x == X_MAX) begin
`ifdef SNAKE_WRAP_EN
          nx_c = '0;
`else
          off_edge = 1'b1;
`endif
        end else begin
          nx_c = head_x + 1'b1;
        end
      end
      (dir_pend == UP): begin
        if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
          ny_c = Y_MAX;
`else
          off_edge = 1'b1;
`endif
        end else begin
          ny_c = head_y - 1'b1;
        end
      end
      default: begin
        if (head_y == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
          ny_c = '0;
`else
          off_edge = 1'b1;
`endif
        end else begin
          ny_c = head_y + 1'b1;
        end
      end
    endcase
  end

  assign hit_food = (nx_c == food_x) && (ny_c == food_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= INIT_HEAD;
      dir_pend        <= RIGHT;
      dir_com         <= RIGHT;
      food_x          <= '0;
      food_y          <= '0;
      nh_x            <= '0;
      nh_y            <= '0;
      grow            <= 1'b0;
      scan_off        <= '0;
      scan_left       <= '0;
      length          <= LW'(1);
      game_over       <= 1'b0;
      bus.draw_valid  <= 1'b0;
      bus.draw_x      <= '0;
      bus.draw_y      <= '0;
      bus.draw_colour <= BLACK;
      bus.food_req    <= 1'b0;
    end else begin
      bus.food_req <= 1'b0;
      if (dir_valid && state != DEAD
          && dir_t'(dir_req) != opposite(cmt_dir))
        dir_pend <= dir_t'(dir_req);
      // Draw states issue on entry, then wait for the transfer edge.
      unique case (state)
        INIT_HEAD: begin
          if (!bus.draw_valid) begin
            bus.draw_valid  <= 1'b1;
            bus.draw_x      <= head_x;
            bus.draw_y      <= head_y;
            bus.draw_colour <= WHITE;
          end else if (bus.draw_ready) begin
            bus.draw_valid <= 1'b0;
            bus.food_req   <= 1'b1;
            state          <= INIT_FOOD;
          end
        end
        INIT_FOOD, FOOD_WAIT: begin
          if (bus.food_valid) begin
            food_x <= bus.food_x;
            food_y <= bus.food_y;
            state  <= FOOD_DRAW;
          end
        end
        FOOD_DRAW: begin
          if (!bus.draw_valid) begin
            bus.draw_valid  <= 1'b1;
            bus.draw_x      <= food_x;
            bus.draw_y      <= food_y;
            bus.draw_colour <= GREEN;
          end else if (bus.draw_ready) begin
            bus.draw_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        IDLE: begin
          if (tick) state <= STEP;
        end
        STEP: begin
          if (off_edge) begin
            game_over <= 1'b1;
            state     <= DEAD;
          end else begin
            nh_x      <= nx_c;
            nh_y      <= ny_c;
            dir_com   <= dir_pend;
            grow      <= hit_food;
            scan_off  <= hit_food ? PW'(0) : PW'(1);
            scan_left <= hit_food ? length : length - 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (scan_left != '0 && rd_x == nh_x && rd_y == nh_y) begin
            game_over <= 1'b1;
            state     <= DEAD;
          end else if (scan_left <= LW'(1)) begin
            state <= grow ? HEAD : ERASE;
          end else begin
            scan_left <= scan_left - 1'b1;
            scan_off  <= scan_off + 1'b1;
          end
        end
        ERASE: begin
          if (!bus.draw_valid) begin
            bus.draw_valid  <= 1'b1;
            bus.draw_x      <= tail_x;
            bus.draw_y      <= tail_y;
            bus.draw_colour <= BLACK;
          end else if (bus.draw_ready) begin
            bus.draw_valid <= 1'b0;
            state          <= HEAD;
          end
        end
        HEAD: begin
          if (!bus.draw_valid) begin
            bus.draw_valid  <= 1'b1;
            bus.draw_x      <= nh_x;
            bus.draw_y      <= nh_y;
            bus.draw_colour <= WHITE;
          end else if (bus.draw_ready) begin
            bus.draw_valid <= 1'b0;
            if (grow && length != LEN_MAX) length <= length + 1'b1;
            bus.food_req <= grow;
            state        <= grow ? FOOD_WAIT : IDLE;
          end
        end
        DEAD: begin
          state <= DEAD;
        end
        default: begin
          state <= INIT_HEAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed game scenario against a queue-based model.
// Draw transfers are scoreboarded every cycle; literals pin the model.
module tb_snake_engine;
  import snake_pkg::*;

  localparam int GW = 160;
  localparam int GH = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int ML = 128;

  typedef struct {
    int x;
    int y;
    int c;
  } px_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic [7:0] length;
  logic       game_over;

  snake_engine_if #(.X_W(XW), .Y_W(YW)) bus ();

  snake_engine #(
    .GRID_W  (GW),
    .GRID_H  (GH),
    .X_W     (XW),
    .Y_W     (YW),
    .MAX_LEN (ML),
    .START_X (0),
    .START_Y (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .dir_valid (dir_valid),
    .dir_req   (dir_req),
    .bus       (bus),
    .length    (length),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fl_x [8] = '{50, 51, 52, 53, 10, 5, 20, 30};
  int fl_y [8] = '{70, 70, 70, 70, 10, 100, 20, 30};
  int r_i = 0;
  int m_fi = 0;
  int nreq = 0;
  int n_food_exp = 0;
  px_t exp_q [$];
  px_t log_q [$];
  int bx [$];
  int by [$];
  int m_dir, m_com, m_fx, m_fy, m_over;
  int lat;
  bit hv = 0;
  bit fr_prev = 0;
  px_t hp;

  task automatic chk(string nm, int act, int e);
    total++;
    if (act != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, e);
    end
  endtask

  task automatic chk_log(string nm, int idx, int x, int y, int c);
    px_t p;
    p = '{-1, -1, -1};
    if (idx >= 0 && idx < log_q.size()) p = log_q[idx];
    chk({nm, "_x"}, p.x, x);
    chk({nm, "_y"}, p.y, y);
    chk({nm, "_c"}, p.c, c);
  endtask

  // Model: body as a queue, tail at [0], head at [$].
  task automatic model_reset();
    bx.delete();
    by.delete();
    bx.push_back(0);
    by.push_back(0);
    m_dir = 1;
    m_com = 1;
    m_over = 0;
    m_fx = fl_x[m_fi];
    m_fy = fl_y[m_fi];
    m_fi++;
    n_food_exp++;
    exp_q.push_back('{0, 0, 7});
    exp_q.push_back('{m_fx, m_fy, 2});
  endtask

  task automatic model_dir(int d);
    if (m_over == 0 && d != (m_com ^ 1)) m_dir = d;
  endtask

  task automatic model_step();
    int nx, ny;
    bit grow;
    if (m_over != 0) return;
    m_com = m_dir;
    nx = bx[$] + (m_dir == 1 ? 1 : 0) - (m_dir == 0 ? 1 : 0);
    ny = by[$] + (m_dir == 3 ? 1 : 0) - (m_dir == 2 ? 1 : 0);
`ifdef SNAKE_WRAP_EN
    nx = (nx + GW) % GW;
    ny = (ny + GH) % GH;
`else
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      m_over = 1;
      return;
    end
`endif
    grow = (nx == m_fx && ny == m_fy);
    for (int i = (grow ? 0 : 1); i < bx.size(); i++) begin
      if (bx[i] == nx && by[i] == ny) begin
        m_over = 1;
        return;
      end
    end
    if (!grow) begin
      exp_q.push_back('{bx[0], by[0], 0});
      void'(bx.pop_front());
      void'(by.pop_front());
    end else if (bx.size() == ML) begin
      void'(bx.pop_front());
      void'(by.pop_front());
    end
    bx.push_back(nx);
    by.push_back(ny);
    exp_q.push_back('{nx, ny, 7});
    if (grow) begin
      m_fx = fl_x[m_fi];
      m_fy = fl_y[m_fi];
      m_fi++;
      n_food_exp++;
      exp_q.push_back('{m_fx, m_fy, 2});
    end
  endtask

  // Food source: answers each request after 0..2 cycles.
  initial begin
    bus.food_valid = 1'b0;
    bus.food_x = '0;
    bus.food_y = '0;
    forever begin
      @(negedge clk);
      if (bus.food_req && !reset && r_i < 8) begin
        repeat (r_i % 3) @(negedge clk);
        bus.food_valid = 1'b1;
        bus.food_x = XW'(fl_x[r_i]);
        bus.food_y = YW'(fl_y[r_i]);
        r_i++;
        @(negedge clk);
        bus.food_valid = 1'b0;
      end
    end
  end

  // Compare process: transfers, hold stability, food_req width.
  always @(negedge clk) begin
    if (reset) begin
      hv = 0;
      fr_prev = 0;
    end else begin
      if (hv) begin
        total++;
        if (!bus.draw_valid || int'(bus.draw_x) != hp.x
            || int'(bus.draw_y) != hp.y
            || int'(bus.draw_colour) != hp.c) begin
          bad++;
          $display("FAIL hold_stable: got v=%0d (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   bus.draw_valid, bus.draw_x, bus.draw_y,
                   bus.draw_colour, hp.x, hp.y, hp.c);
        end
      end
      if (bus.draw_valid && bus.draw_ready) begin
        px_t a;
        px_t e;
        a = '{int'(bus.draw_x), int'(bus.draw_y), int'(bus.draw_colour)};
        log_q.push_back(a);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_draw: got (%0d,%0d,%0d) want none",
                   a.x, a.y, a.c);
        end else begin
          e = exp_q.pop_front();
          if (a.x != e.x || a.y != e.y || a.c != e.c) begin
            bad++;
            $display("FAIL draw: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     a.x, a.y, a.c, e.x, e.y, e.c);
          end
        end
      end
      if (bus.food_req) begin
        nreq++;
        total++;
        if (fr_prev) begin
          bad++;
          $display("FAIL food_req_width: got 2+ cycles want 1");
        end
      end
      fr_prev = bus.food_req;
      hv = bus.draw_valid && !bus.draw_ready;
      hp = '{int'(bus.draw_x), int'(bus.draw_y), int'(bus.draw_colour)};
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dir(int d);
    model_dir(d);
    dir_valid = 1'b1;
    dir_req = 2'(d);
    cyc(1);
    dir_valid = 1'b0;
  endtask

  task automatic send_tick();
    model_step();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    lat = 0;
    while (!bus.draw_valid && lat < 40) begin
      cyc(1);
      lat++;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      cyc(1);
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    cyc(12);
    chk("length", int'(length), bx.size());
    chk("game_over", int'(game_over), m_over);
  endtask

  task automatic step(int d);
    set_dir(d);
    send_tick();
    drain();
  endtask

  initial begin
    int n0;
    bus.draw_ready = 1'b1;
    reset = 1'b1;
    cyc(3);
    chk("rst_valid", int'(bus.draw_valid), 0);
    chk("rst_food_req", int'(bus.food_req), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_length", int'(length), 1);
    chk("rst_x", int'(bus.draw_x), 0);
    chk("rst_y", int'(bus.draw_y), 0);
    chk("rst_colour", int'(bus.draw_colour), 0);
    reset = 1'b0;
    model_reset();
    drain();
    chk_log("init_head", 0, 0, 0, 7);
    chk_log("init_food", 1, 50, 70, 2);

    set_dir(0);
    send_tick();
    chk("lat_len1", lat, 3);
    drain();
    chk_log("t1_erase", 2, 0, 0, 0);
    chk_log("t1_head", 3, 1, 0, 7);
    step(1);
    step(1);
    chk_log("t3_erase", 6, 2, 0, 0);
    chk_log("t3_head", 7, 3, 0, 7);

    bus.draw_ready = 1'b0;
    send_tick();
    chk("lat_hold", lat, 3);
    for (int i = 0; i < 5; i++) begin
      tick = (i == 2);
      cyc(1);
    end
    tick = 1'b0;
    chk("hold_x", int'(bus.draw_x), 3);
    chk("hold_y", int'(bus.draw_y), 0);
    bus.draw_ready = 1'b1;
    drain();
    chk_log("t4_head", log_q.size() - 1, 4, 0, 7);

    for (int i = 0; i < 45; i++) step(1);
    for (int i = 0; i < 70; i++) step(3);
    step(1);
    chk("len_eat1", int'(length), 2);
    chk_log("eat_head", log_q.size() - 2, 50, 70, 7);
    chk_log("eat_food", log_q.size() - 1, 51, 70, 2);
    step(1);
    step(1);
    step(1);
    chk("len_eat4", int'(length), 5);

    set_dir(2);
    send_tick();
    chk("lat_len5", lat, 6);
    drain();
    step(0);
    n0 = log_q.size();
    step(3);
    chk("self_hit_over", int'(game_over), 1);
    chk("self_hit_len", int'(length), 5);
    chk("self_hit_draws", log_q.size(), n0);
    step(0);
    step(3);
    step(1);
    chk("dead_over", int'(game_over), 1);
    chk("dead_draws", log_q.size(), n0);

    reset = 1'b1;
    cyc(2);
    chk("rst2_valid", int'(bus.draw_valid), 0);
    chk("rst2_over", int'(game_over), 0);
    reset = 1'b0;
    model_reset();
    drain();
    chk_log("init2_food", log_q.size() - 1, 5, 100, 2);
    for (int i = 0; i < 159; i++) step(1);
    chk_log("edge_head", log_q.size() - 1, 159, 0, 7);
    n0 = log_q.size();
    step(1);
`ifdef SNAKE_WRAP_EN
    chk("wrap_over", int'(game_over), 0);
    chk_log("wrap_head", log_q.size() - 1, 0, 0, 7);
`else
    chk("wall_over", int'(game_over), 1);
    chk("wall_draws", log_q.size(), n0);
`endif
    chk("food_req_count", nreq, n_food_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised game-step engine for the snake game. It replaces the fixed one-pixel mover with a ring-buffer body of configurable maximum length, self-collision and wall detection, and growth on eating. It turns each game tick into a sequence of pixel draw commands for the VGA adapter, sent over a valid/ready handshake. It sits between the rate divider/keyboard decoder and the `vga_adapter`.

## Interface
- `GRID_W`, 160: playfield width in cells.
- `GRID_H`, 120: playfield height in cells.
- `X_W`, 8: x coordinate width; must satisfy 2^X_W ≥ GRID_W.
- `Y_W`, 7: y coordinate width; must satisfy 2^Y_W ≥ GRID_H.
- `MAX_LEN`, 128: body capacity in segments; power of two.
- `START_X`, 0 / `START_Y`, 0: head position after reset.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `tick`  in  1  one-cycle game-step pulse.
- `dir_valid`  in  1  direction request strobe.
- `dir_req`  in  2  requested direction: 0 left, 1 right, 2 up, 3 down.
- `food_req`  out  1  one-cycle request for a new food position.
- `food_valid`  in  1  food position is valid.
- `food_x`  in  X_W  food x.
- `food_y`  in  Y_W  food y.
- `draw_valid`  out  1  draw command pending.
- `draw_ready`  in  1  consumer accepts the pending command.
- `draw_x`  out  X_W  pixel x.
- `draw_y`  out  Y_W  pixel y.
- `draw_colour`  out  3  pixel colour.
- `length`  out  $clog2(MAX_LEN)+1  current body length.
- `game_over`  out  1  sticky collision flag.

## Operation
- **States:** INIT_HEAD, INIT_FOOD, IDLE, STEP, CHECK, ERASE, HEAD, FOOD_WAIT, FOOD_DRAW, DEAD.

- **Reset values:**
  - `length` = 1; body[0] = (START_X, START_Y); direction RIGHT.
  - `draw_valid`, `food_req`, `game_over` = 0; `draw_x`, `draw_y`, `draw_colour` = 0.
  - Next state INIT_HEAD.

- **Startup sequence:**
  - INIT_HEAD draws the head in white (3'b111).
  - INIT_FOOD pulses `food_req`, waits for `food_valid`, draws the food in green (3'b010), then moves to IDLE.

- **Direction register:**
  - Updated on any cycle with `dir_valid`.
  - A request exactly opposite the *committed* direction (the one used in the last STEP) is ignored.
  - The latest legal request wins.

- **IDLE:**
  - `tick` moves to STEP.
  - A `tick` in any other state is dropped, not queued.

- **STEP:**
  - Computes next head = head ±1 on one axis.
  - Sets `grow` = (next head == stored food).

- **CHECK:**
  - Scans body segments, one per cycle, comparing each against the next head.
  - The tail segment is excluded when `grow`=0, because the tail vacates this step.
  - Scan count is L−1 cycles (minimum 1) without growth, L cycles with growth.
  - On a hit: set `game_over`, go to DEAD.

- **ERASE:**
  - Only when `grow`=0: draws the old tail in black (3'b000), then pops the tail.

- **HEAD:**
  - Pushes the next head and draws it white.
  - If `grow` and `length` < MAX_LEN, increments `length`.
  - At MAX_LEN, eating is still recognised, but the tail is popped and `length` is unchanged.

- **FOOD_WAIT / FOOD_DRAW:**
  - Entered only if `grow`: pulse `food_req`, wait for `food_valid`, latch the position, draw it green.
  - Otherwise go straight to IDLE.
  - Food placed on the body is accepted as-is.

- **DEAD:**
  - Holds all state and ignores `tick` and `dir_valid`.
  - Left only by `reset`.

- **Arithmetic:** body storage is a MAX_LEN ring buffer with head and tail pointers of width $clog2(MAX_LEN), wrapping modulo MAX_LEN.

## Timing
- Draw handshake: a command transfers on a clock edge where `draw_valid` && `draw_ready`.
- `draw_x`, `draw_y` and `draw_colour` are stable while `draw_valid` is high and not yet accepted.
- `draw_valid` deasserts the cycle after acceptance unless the next command is issued back-to-back.
- Latency from the `tick` edge to the first `draw_valid`, with no growth: 1 (STEP) + max(L−1,1) (CHECK) + 1 cycles.
- `food_req` is high exactly one cycle.
- `food_valid` may arrive in the same cycle as `food_req` or any later cycle.
- `reset` mid-sequence aborts immediately, including a pending draw or food wait.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - x wraps GRID_W−1 ↔ 0; y wraps GRID_H−1 ↔ 0.
  - Edges are never fatal.
- `SNAKE_WRAP_EN` undefined:
  - A step leaving [0,GRID_W−1]×[0,GRID_H−1] sets `game_over` in STEP.
  - No pixel is drawn for that step.

## Structure
- Package `snake_pkg` holds:
  - Direction encodings LEFT/RIGHT/UP/DOWN.
  - Colour constants BLACK/WHITE/GREEN.
  - The state enum.
- Sub-module `snake_body_ring`: ring buffer with push-head, pop-tail and indexed read for the CHECK scan, parametrised by MAX_LEN, X_W and Y_W.

## Test plan
- Reset, `draw_ready`=1, supply food (50,70) → draws (0,0) white, then (50,70) green; `length`=1.
- Direction RIGHT, 3 ticks → per tick, black then white: (0,0)→(1,0), (1,0)→(2,0), (2,0)→(3,0).
- Head at (49,70) moving right, food (50,70) → no erase; (50,70) white; `length`=2; `food_req` pulse; new food drawn green.
- Length 5 in a U-turn loop, steered into own body → `game_over`=1 after CHECK, no draws, further ticks ignored.
- Head at (159,0) moving right → wrap: (0,0) drawn when `SNAKE_WRAP_EN` is defined; `game_over`=1 with no draw when it is not.
- Hold `draw_ready`=0 for 5 cycles during ERASE → `draw_x`/`draw_y` stable; a `tick` arriving meanwhile is dropped.
